// File: rtl/imm_decode_pkg.sv
// Shared opcodes, type-bit indices and the buffered entry layout for imm_decode_stage.
package imm_decode_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam int TYP_J = 4;
  localparam int TYP_U = 3;
  localparam int TYP_B = 2;
  localparam int TYP_S = 1;
  localparam int TYP_I = 0;

  // pc/imm sized for the widest XLEN; narrower builds use the low bits only.
  typedef struct packed {
    logic [31:0] ir;
    logic [63:0] pc;
    logic [4:0]  typ;
    logic [63:0] imm;
    logic        illegal;
  } imm_entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_state_e;

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational decoder: instruction word -> one-hot type, sign-extended immediate, illegal flag.
module imm_decode_comb
  import imm_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_ir,
  output logic [4:0]      o_type,
  output logic [XLEN-1:0] o_imm,
  output logic            o_illegal
);

  logic [4:0]  w_typ;
  logic        w_illegal;
  logic [63:0] w_imm64;
  logic        w_unused_imm;

  always_comb begin
    w_typ     = '0;
    w_illegal = 1'b0;
    if (i_ir[1:0] != 2'b11) begin
      w_illegal = 1'b1;
    end else begin
      case (i_ir[6:0])
        OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: w_typ[TYP_I] = 1'b1;
        OPC_OP_IMM_32: if (XLEN == 64) w_typ[TYP_I] = 1'b1; else w_illegal = 1'b1;
        OPC_STORE:     w_typ[TYP_S] = 1'b1;
        OPC_BRANCH:    w_typ[TYP_B] = 1'b1;
        OPC_LUI, OPC_AUIPC: w_typ[TYP_U] = 1'b1;
        OPC_JAL:       w_typ[TYP_J] = 1'b1;
        OPC_OP:        ;
        OPC_OP_32:     if (XLEN != 64) w_illegal = 1'b1;
        default:       w_illegal = 1'b1;
      endcase
    end
  end

  // Build at 64 bits and truncate, so XLEN=32 and XLEN=64 share one path.
  always_comb begin
    w_imm64 = '0;
    if (w_typ[TYP_I])      w_imm64 = {{52{i_ir[31]}}, i_ir[31:20]};
    else if (w_typ[TYP_S]) w_imm64 = {{52{i_ir[31]}}, i_ir[31:25], i_ir[11:7]};
    else if (w_typ[TYP_B]) w_imm64 = {{51{i_ir[31]}}, i_ir[31], i_ir[7], i_ir[30:25], i_ir[11:8], 1'b0};
    else if (w_typ[TYP_U]) w_imm64 = {{32{i_ir[31]}}, i_ir[31:12], 12'b0};
    else if (w_typ[TYP_J]) w_imm64 = {{43{i_ir[31]}}, i_ir[31], i_ir[19:12], i_ir[20], i_ir[30:21], 1'b0};
  end

  assign w_unused_imm = ^w_imm64;
  assign o_type       = w_typ;
  assign o_imm        = w_imm64[XLEN-1:0];
  assign o_illegal    = w_illegal;

endmodule

// File: rtl/imm_decode_stage.sv
// Decode front stage with a 2-entry skid buffer and registered in_ready_o.
// Optional same-cycle bypass when empty: define IMM_DECODE_BYPASS_EN.
module imm_decode_stage
  import imm_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_ir_i,
  input  logic [XLEN-1:0] in_pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [31:0]     out_ir_o,
  output logic [XLEN-1:0] out_pc_o,
  output logic [4:0]      out_type_o,
  output logic [XLEN-1:0] out_imm_o,
  output logic            out_illegal_o
);

  logic [4:0]      w_typ;
  logic [XLEN-1:0] w_imm;
  logic            w_illegal;
  imm_entry_t      w_in_entry, w_out_entry, r_head, r_skid;
  skid_state_e     r_state, w_state_nxt;
  logic            r_in_ready, w_push, w_pop, w_bypass, w_out_valid;
  logic            w_unused_entry;

  imm_decode_comb #(.XLEN(XLEN)) u_dec (
    .i_ir      (in_ir_i),
    .o_type    (w_typ),
    .o_imm     (w_imm),
    .o_illegal (w_illegal)
  );

  always_comb begin
    w_in_entry         = '0;
    w_in_entry.ir      = in_ir_i;
    w_in_entry.pc      = 64'(in_pc_i);
    w_in_entry.typ     = w_typ;
    w_in_entry.imm     = 64'(w_imm);
    w_in_entry.illegal = w_illegal;
  end

`ifdef IMM_DECODE_BYPASS_EN
  assign w_bypass = (r_state == EMPTY) & in_valid_i;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_out_valid = (r_state != EMPTY) | w_bypass;
  assign w_out_entry = w_bypass ? w_in_entry : r_head;
  assign w_push      = in_valid_i & r_in_ready;
  assign w_pop       = w_out_valid & out_ready_i;

  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY:   if (w_push && !w_pop) w_state_nxt = ONE;
        ONE:     if (w_push && !w_pop) w_state_nxt = FULL;
                 else if (!w_push && w_pop) w_state_nxt = EMPTY;
        FULL:    if (w_pop) w_state_nxt = ONE;
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
      r_head     <= '0;
      r_skid     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != FULL);
      if (!flush_i) begin
        case (r_state)
          // A bypassed word that is popped the same cycle never lands in the buffer.
          EMPTY:   if (w_push && !w_pop) r_head <= w_in_entry;
          ONE:     if (w_push && w_pop) r_head <= w_in_entry;
                   else if (w_push) r_skid <= w_in_entry;
          FULL:    if (w_pop) r_head <= r_skid;
          default: ;
        endcase
      end
    end
  end

  assign w_unused_entry = ^w_out_entry;
  assign in_ready_o     = r_in_ready;
  assign out_valid_o    = w_out_valid;
  assign out_ir_o       = w_out_entry.ir;
  assign out_pc_o       = w_out_entry.pc[XLEN-1:0];
  assign out_type_o     = w_out_entry.typ;
  assign out_imm_o      = w_out_entry.imm[XLEN-1:0];
  assign out_illegal_o  = w_out_entry.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench: XLEN=32 and XLEN=64 instances driven with the same stimulus.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_ir;
  logic [63:0] in_pc;

  logic        a_in_ready, a_out_valid, a_illegal;
  logic [31:0] a_ir, a_pc, a_imm;
  logic [4:0]  a_type;
  logic        b_in_ready, b_out_valid, b_illegal;
  logic [31:0] b_ir;
  logic [63:0] b_pc, b_imm;
  logic [4:0]  b_type;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32)) dut32 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(a_in_ready), .in_ir_i(in_ir), .in_pc_i(in_pc[31:0]),
    .out_valid_o(a_out_valid), .out_ready_i(out_ready), .out_ir_o(a_ir), .out_pc_o(a_pc),
    .out_type_o(a_type), .out_imm_o(a_imm), .out_illegal_o(a_illegal)
  );

  imm_decode_stage #(.XLEN(64)) dut64 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(b_in_ready), .in_ir_i(in_ir), .in_pc_i(in_pc),
    .out_valid_o(b_out_valid), .out_ready_i(out_ready), .out_ir_o(b_ir), .out_pc_o(b_pc),
    .out_type_o(b_type), .out_imm_o(b_imm), .out_illegal_o(b_illegal)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_hs(input string tag, input logic vld, input logic rdy, input logic [31:0] ir);
    chk({tag, " vld32"}, 64'(a_out_valid), 64'(vld));
    chk({tag, " rdy32"}, 64'(a_in_ready),  64'(rdy));
    chk({tag, " ir32"},  64'(a_ir),        64'(ir));
    chk({tag, " vld64"}, 64'(b_out_valid), 64'(vld));
    chk({tag, " rdy64"}, 64'(b_in_ready),  64'(rdy));
    chk({tag, " ir64"},  64'(b_ir),        64'(ir));
  endtask

  // Push one word with out_ready high and check the decode one cycle later.
  task automatic vec(input string tag, input logic [31:0] ir, input logic [63:0] pc,
                     input logic [4:0] t32, input logic [31:0] i32, input logic l32,
                     input logic [4:0] t64, input logic [63:0] i64, input logic l64);
    in_valid = 1'b1; in_ir = ir; in_pc = pc;
    tick;
    in_valid = 1'b0;
    chk_hs(tag, 1'b1, 1'b1, ir);
    chk({tag, " pc32"},   64'(a_pc),      64'(pc[31:0]));
    chk({tag, " type32"}, 64'(a_type),    64'(t32));
    chk({tag, " imm32"},  64'(a_imm),     64'(i32));
    chk({tag, " ill32"},  64'(a_illegal), 64'(l32));
    chk({tag, " pc64"},   b_pc,           pc);
    chk({tag, " type64"}, 64'(b_type),    64'(t64));
    chk({tag, " imm64"},  b_imm,          i64);
    chk({tag, " ill64"},  64'(b_illegal), 64'(l64));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_hs(tag, 1'b0, 1'b1, 32'h0);
    chk({tag, " pc32"},  64'(a_pc), 64'h0);
    chk({tag, " typ32"}, 64'(a_type), 64'h0);
    chk({tag, " imm32"}, 64'(a_imm), 64'h0);
    chk({tag, " ill32"}, 64'(a_illegal), 64'h0);
    chk({tag, " pc64"},  b_pc, 64'h0);
    chk({tag, " typ64"}, 64'(b_type), 64'h0);
    chk({tag, " imm64"}, b_imm, 64'h0);
    chk({tag, " ill64"}, 64'(b_illegal), 64'h0);
  endtask

  localparam logic [31:0] W1 = 32'h00100093;
  localparam logic [31:0] W2 = 32'h00200093;
  localparam logic [31:0] W3 = 32'h00300093;
  localparam logic [31:0] W4 = 32'h00400093;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ir = '0; in_pc = '0;
    #2;
    chk_reset_vals("reset");
    tick; tick;
    rst = 1'b0; out_ready = 1'b1;

    // Back-to-back pushes also exercise simultaneous push/pop in ONE.
    vec("addi",  32'hFFF00093, 64'h100, 5'b00001, 32'hFFFFFFFF, 1'b0, 5'b00001, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    vec("sw",    32'h00552423, 64'h104, 5'b00010, 32'h00000008, 1'b0, 5'b00010, 64'h0000000000000008, 1'b0);
    vec("jal",   32'hFFDFF06F, 64'h108, 5'b10000, 32'hFFFFFFFC, 1'b0, 5'b10000, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    vec("lui",   32'h800000B7, 64'h8000_0000_0000_010C, 5'b01000, 32'h80000000, 1'b0, 5'b01000, 64'hFFFFFFFF80000000, 1'b0);
    vec("zero",  32'h00000000, 64'h110, 5'b00000, 32'h0, 1'b1, 5'b00000, 64'h0, 1'b1);
    vec("beq",   32'hFE000EE3, 64'h114, 5'b00100, 32'hFFFFFFFC, 1'b0, 5'b00100, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    vec("add",   32'h003100B3, 64'h118, 5'b00000, 32'h0, 1'b0, 5'b00000, 64'h0, 1'b0);
    vec("addiw", 32'hFFF0809B, 64'h11C, 5'b00000, 32'h0, 1'b1, 5'b00001, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    vec("addw",  32'h003100BB, 64'h120, 5'b00000, 32'h0, 1'b1, 5'b00000, 64'h0, 1'b0);
    vec("lo00",  32'h00000010, 64'h124, 5'b00000, 32'h0, 1'b1, 5'b00000, 64'h0, 1'b1);
    vec("auipc", 32'h00001097, 64'h128, 5'b01000, 32'h00001000, 1'b0, 5'b01000, 64'h0000000000001000, 1'b0);
    tick;
    chk("drain vld32", 64'(a_out_valid), 64'h0);
    chk("drain vld64", 64'(b_out_valid), 64'h0);

    // Output stall: two words accepted, third held upstream.
    out_ready = 1'b0; in_valid = 1'b1; in_ir = W1;
    tick; chk_hs("stall1", 1'b1, 1'b1, W1);
    in_ir = W2;
    tick; chk_hs("stall2", 1'b1, 1'b0, W1);
    in_ir = W3;
    tick; chk_hs("stall3", 1'b1, 1'b0, W1);
    in_valid = 1'b0; out_ready = 1'b1;
    tick; chk_hs("popfull", 1'b1, 1'b1, W2);
    out_ready = 1'b0; in_valid = 1'b1; in_ir = W3;
    tick; chk_hs("refill", 1'b1, 1'b0, W2);

    // Flush with a push attempt in the same cycle.
    flush = 1'b1; in_ir = W4;
    tick;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush vld32", 64'(a_out_valid), 64'h0);
    chk("flush rdy32", 64'(a_in_ready),  64'h1);
    chk("flush vld64", 64'(b_out_valid), 64'h0);
    chk("flush rdy64", 64'(b_in_ready),  64'h1);
    tick;
    chk("postflush vld32", 64'(a_out_valid), 64'h0);

    // Asynchronous reset between edges.
    in_valid = 1'b1; in_ir = W1;
    tick;
    in_valid = 1'b0;
    chk_hs("prerst", 1'b1, 1'b1, W1);
    #2 rst = 1'b1;
    #1 chk_reset_vals("asyncrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
